// File: rtl/inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_iter
//   Iterative AES InvMixColumns. A 128-bit state is latched on accept, then
//   COLS_PER_CYCLE columns per clock are transformed (column 0 first) into a
//   result register. The result is presented with a valid/ready handshake.
//
//   Parameters
//     COLS_PER_CYCLE  columns transformed per clock: 1, 2 or 4
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   in_data carries a state this cycle
//     in_ready   block is idle and will take a state
//     in_data    state; column c at [127-32c -: 32], byte 0 is the top byte
//     out_valid  out_data holds a finished result
//     out_ready  downstream takes out_data this cycle
//     out_data   InvMixColumns(state), same layout as in_data
// ---------------------------------------------------------------------------

// One column: s'_r = 0e*s_r ^ 0b*s_(r+1) ^ 0d*s_(r+2) ^ 09*s_(r+3)
module inv_mix_col (
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] s  [4];
   logic [7:0] x2 [4];
   logic [7:0] x4 [4];
   logic [7:0] x8 [4];
   logic [7:0] m9 [4];
   logic [7:0] mb [4];
   logic [7:0] md [4];
   logic [7:0] me [4];

   for (genvar r = 0; r < 4; r++) begin : g_byte
      assign s[r]  = col_in[31-8*r -: 8];
      assign x2[r] = xtime(s[r]);
      assign x4[r] = xtime(x2[r]);
      assign x8[r] = xtime(x4[r]);
      // constant products from the xtime chain
      assign m9[r] = x8[r] ^ s[r];
      assign mb[r] = x8[r] ^ x2[r] ^ s[r];
      assign md[r] = x8[r] ^ x4[r] ^ s[r];
      assign me[r] = x8[r] ^ x4[r] ^ x2[r];
      assign col_out[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
   end
endmodule

module inv_mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1   // 1, 2 or 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

   state_t state, state_nxt;
   logic [1:0] cnt;
   // element 3 holds column 0 so the flat view matches the port layout
   logic [3:0][31:0] in_reg;
   logic [3:0][31:0] out_reg;
   logic last_busy;

   logic [COLS_PER_CYCLE-1:0][1:0]  col_idx;
   logic [COLS_PER_CYCLE-1:0][31:0] col_in;
   logic [COLS_PER_CYCLE-1:0][31:0] col_out;

   assign last_busy = (state == BUSY) && (cnt == LAST_CNT);

   for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
      assign col_idx[i] = cnt + 2'(i);
      assign col_in[i]  = in_reg[2'd3 - col_idx[i]];
      inv_mix_col u_col (
         .col_in  (col_in[i]),
         .col_out (col_out[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = BUSY;
         BUSY:    if (last_busy) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Counter stops at the last column group rather than wrapping; the
   // FSM leaves BUSY on that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_reg  <= '0;
         out_reg <= '0;
         cnt     <= '0;
      end else if (state == IDLE && in_valid) begin
         in_reg <= in_data;
         cnt    <= '0;
      end else if (state == BUSY) begin
         for (int i = 0; i < COLS_PER_CYCLE; i++)
            out_reg[2'd3 - col_idx[i]] <= col_out[i];
         if (!last_busy) cnt <= cnt + STEP;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = out_reg;
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
module tb_inv_mix_columns_iter;
   logic clk = 0;
   logic rst_n = 0;
   always #5 clk = ~clk;

   // full-scenario DUT, one column per cycle
   logic         in_valid = 0, out_ready = 0;
   logic [127:0] in_data = '0;
   logic         in_ready1, out_valid1;
   logic [127:0] out_data1;

   // wider DUTs share one simple stimulus
   logic         x_valid = 0, x_ready = 1;
   logic [127:0] x_data = '0;
   logic         in_ready2, out_valid2, in_ready4, out_valid4;
   logic [127:0] out_data2, out_data4;

   inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1));
   inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(in_ready2),
      .in_data(x_data), .out_valid(out_valid2), .out_ready(x_ready), .out_data(out_data2));
   inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(in_ready4),
      .in_data(x_data), .out_valid(out_valid4), .out_ready(x_ready), .out_data(out_data4));

   localparam logic [127:0] V028_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
   localparam logic [127:0] V028_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
   localparam logic [127:0] V029_IN  = 128'h4d7ebdf8_c6c6c6c6_00000000_ffffffff;
   localparam logic [127:0] V029_OUT = 128'h2d26314c_c6c6c6c6_00000000_ffffffff;

   int chk_cnt = 0, err_cnt = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // reference: shift-and-add GF(2^8) multiply
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] st);
      logic [127:0] res = '0;
      logic [31:0]  col;
      logic [7:0]   s [4];
      for (int c = 0; c < 4; c++) begin
         col = st[127-32*c -: 32];
         for (int r = 0; r < 4; r++) s[r] = col[31-8*r -: 8];
         for (int r = 0; r < 4; r++)
            res[127-32*c-8*r -: 8] = gmul(s[r], 8'h0e) ^ gmul(s[(r+1)%4], 8'h0b) ^
                                     gmul(s[(r+2)%4], 8'h0d) ^ gmul(s[(r+3)%4], 8'h09);
      end
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // scoreboard / monitor for dut1, sampled on the falling edge
   logic [127:0] sb1 [$];
   int           cyc = 0;
   int           last_acc = -1;
   bit           space_on = 0;
   bit           prev_ov1 = 0;
   logic [127:0] hold1 = '0, last_out1 = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready1) begin
            sb1.push_back(model(in_data));
            if (space_on && last_acc >= 0) chk("b2b_space", cyc + 1 - last_acc, 6);
            last_acc = cyc + 1;
         end
         if (out_valid1 && !prev_ov1) begin
            chk("lat1", cyc - last_acc, 4);
            hold1 = out_data1;
         end
         if (out_valid1) begin
            chk("hold1", out_data1, hold1);
            chk("rdy_in_done", in_ready1, 0);
         end
         if (out_valid1 && out_ready) begin
            if (sb1.size() == 0) chk("unexpected_out", 1, 0);
            else                 chk("data1", out_data1, sb1.pop_front());
            last_out1 = out_data1;
         end
         prev_ov1 = out_valid1;
      end else prev_ov1 = 0;
   end

   task automatic send1(input logic [127:0] d);
      bit ok = 0;
      in_valid = 1; in_data = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (in_ready1) begin @(posedge clk); #1; ok = 1; end
      end
      in_valid = 0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain1();
      for (int i = 0; i < 60 && sb1.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain", sb1.size(), 0);
   endtask

   logic [127:0] vin  [2];
   logic [127:0] vexp [2];

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vin[0] = V028_IN;  vexp[0] = V028_OUT;
      vin[1] = V029_IN;  vexp[1] = V029_OUT;

      // reset state
      #3;
      chk("rst_in_ready", in_ready1, 1);
      chk("rst_out_valid", out_valid1, 0);
      chk("rst_out_data", out_data1, 0);
      chk("rst_ov2", out_valid2, 0);
      chk("rst_ov4", out_valid4, 0);
      #9 rst_n = 1;
      @(posedge clk); #1;

      // known vectors and a few random states
      out_ready = 1;
      send1(V028_IN); drain1();
      chk("v028", last_out1, V028_OUT);
      send1(V029_IN); drain1();
      chk("v029", last_out1, V029_OUT);
      for (int k = 0; k < 3; k++) begin send1(rnd128()); drain1(); end

      // backpressure, with in_valid and toggling data during BUSY and DONE
      out_ready = 0;
      send1(rnd128());
      in_valid = 1;
      begin
         bit seen = 0;
         for (int i = 0; i < 20 && !seen; i++) begin
            in_data = ~in_data;
            @(posedge clk); #1;
            seen = out_valid1;
         end
         if (!seen) chk("bp_valid_timeout", 0, 1);
      end
      for (int i = 0; i < 10; i++) begin
         in_data = rnd128();
         @(posedge clk); #1;
      end
      out_ready = 1; in_valid = 0;
      @(posedge clk); #1;
      chk("rel_in_ready", in_ready1, 1);
      chk("rel_out_valid", out_valid1, 0);
      chk("bp_drain", sb1.size(), 0);

      // reset in the second column cycle
      send1(V028_IN);
      @(posedge clk); #1;
      rst_n = 0; #1;
      chk("abort_out_valid", out_valid1, 0);
      chk("abort_out_data", out_data1, 0);
      chk("abort_in_ready", in_ready1, 1);
      sb1.delete();
      #1 rst_n = 1;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_no_valid", out_valid1, 0);
      send1(V029_IN); drain1();
      chk("after_abort", last_out1, V029_OUT);

      // back-to-back, in_valid held through three states
      last_acc = -1; space_on = 1;
      in_valid = 1;
      for (int k = 0; k < 3; k++) begin
         bit ok = 0;
         in_data = (k == 0) ? V028_IN : rnd128();
         for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready1) begin @(posedge clk); #1; ok = 1; end
         end
         if (!ok) chk("b2b_timeout", 0, 1);
      end
      in_valid = 0;
      drain1();
      space_on = 0;

      // wider datapaths: latency 2 and 1, same results
      for (int v = 0; v < 2; v++) begin
         bit got2 = 0, got4 = 0;
         x_valid = 1; x_data = vin[v];
         @(posedge clk); #1;
         x_valid = 0; x_data = rnd128();
         for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (out_valid2 && !got2) begin
               chk("lat2", n, 2); chk("data2", out_data2, vexp[v]); got2 = 1;
            end
            if (out_valid4 && !got4) begin
               chk("lat4", n, 1); chk("data4", out_data4, vexp[v]); got4 = 1;
            end
         end
         if (!got2) chk("ov2_timeout", 0, 1);
         if (!got4) chk("ov4_timeout", 0, 1);
      end

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1: number of state columns processed per clock; legal values 1, 2, 4 only.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  in_data is valid this cycle.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 in_data  input  128  AES state to invert:
  - column c occupies bits [127-32c : 96-32c];
  - byte r of a column is MSB-first (r=0 in the top byte).
REQ-007 out_valid  output  1  out_data holds a completed result.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  128  InvMixColumns of the accepted state; same column/byte layout as in_data.

Function
REQ-010 The block SHALL compute, per column, s'_r = 0e*s_r ^ 0b*s_(r+1) ^ 0d*s_(r+2) ^ 09*s_(r+3):
  - indices mod 4;
  - multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1 (reduce by 8'h1B on bit-7 carry).
REQ-011 Constant products SHALL be built from chained xtime (x2, x4, x8) and XOR only; results are exactly 8 bits wide.
REQ-012 FSM states SHALL be IDLE, BUSY, DONE.
REQ-013 In IDLE, in_ready SHALL be 1, and in_ready SHALL be 0 in BUSY and DONE.
REQ-014 On an edge with IDLE && in_valid:
  - register in_data;
  - clear the column counter;
  - enter BUSY.
REQ-015 Each BUSY cycle SHALL transform COLS_PER_CYCLE columns, starting at column 0 and ascending, and write them into the result register.
REQ-016 The column counter SHALL advance by COLS_PER_CYCLE per BUSY cycle.
REQ-017 After the cycle that processes column 3, the FSM SHALL enter DONE, and out_valid SHALL be 1 from that edge.
REQ-018 Latency SHALL be fixed: out_valid rises 4/COLS_PER_CYCLE edges after the accept edge (4, 2 or 1 cycles).
REQ-019 In DONE, out_data and out_valid SHALL hold stable until an edge with out_ready=1; on that edge the FSM SHALL return to IDLE and out_valid SHALL fall.
REQ-020 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE; the latched input is never overwritten mid-operation.
REQ-021 A new state SHALL NOT be accepted on the same edge as the out handshake; the earliest next accept is the following edge.
REQ-022 out_data SHALL change only on BUSY column writes and on reset, never while out_valid=1.
REQ-023 The counter SHALL NOT wrap past column 3; entering DONE is the only exit from BUSY.
REQ-024 in_data SHALL be sampled only on the accept edge; changes at other times have no effect.

Reset
REQ-025 While rst_n=0, the block SHALL force FSM=IDLE, counter=0, in_ready=1, out_valid=0, out_data=128'h0 and the input register to 0, asynchronously.
REQ-026 Reset asserted in BUSY or DONE SHALL abort the operation; no partial result is ever flagged valid.
REQ-027 After rst_n deasserts, a state SHALL be accepted on the first clock edge with in_valid=1.

Verification
REQ-028 COLS_PER_CYCLE=1:
  - stimulus: in_data=8e4da1bc_9fdc589d_01010101_d5d5d7d6, out_ready=1;
  - response: out_valid 4 edges after accept, out_data=db135345_f20a225c_01010101_d4d4d4d5.
REQ-029 Round trip:
  - stimulus: in_data=4d7ebdf8_c6c6c6c6_00000000_ffffffff;
  - response: out_data=2d26314c_c6c6c6c6_00000000_ffffffff.
REQ-030 Backpressure:
  - stimulus: out_ready=0 for 10 cycles after out_valid, with in_valid=1 and toggling in_data meanwhile;
  - response: out_data stable, in_ready=0 throughout, single result on release, then in_ready=1 the next cycle.
REQ-031 Reset abort:
  - stimulus: rst_n pulsed low in BUSY (second column cycle);
  - response: out_valid=0 and out_data=0 immediately; the next transaction gives the correct result.
REQ-032 Repeat REQ-028 with COLS_PER_CYCLE=2 and 4:
  - response: identical out_data, with latency 2 and 1 cycles respectively.
REQ-033 Back-to-back:
  - stimulus: in_valid and out_ready held at 1 for 3 states;
  - response: accepts spaced exactly 4/COLS_PER_CYCLE+2 cycles apart, all results correct and in order.
